// File: rtl/io_dev_port_if.sv
// Signal bundle for io_dev_port: host-side FIFO access plus the processor's
// input-port (in_dev_*) and output-port (out_dev_*) handshake pins.
interface io_dev_port_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             host_wr;
  logic [WIDTH-1:0] host_wdata;
  logic             tx_full;
  logic [AW:0]      tx_count;
  logic [WIDTH-1:0] input_bus;
  logic             in_dev_hs;
  logic             in_dev_ack;
  logic [WIDTH-1:0] output_bus;
  logic             out_wr;
  logic             out_dev_hs;
  logic             out_dev_ack;
  logic             host_rd;
  logic [WIDTH-1:0] host_rdata;
  logic             rx_empty;
  logic [AW:0]      rx_count;

  // the device endpoint
  modport slave (
    input  host_wr, host_wdata, in_dev_ack, output_bus, out_wr, host_rd,
    output tx_full, tx_count, input_bus, in_dev_hs, out_dev_hs, out_dev_ack,
           host_rdata, rx_empty, rx_count
  );

  // host + processor side driving the endpoint
  modport master (
    output host_wr, host_wdata, in_dev_ack, output_bus, out_wr, host_rd,
    input  tx_full, tx_count, input_bus, in_dev_hs, out_dev_hs, out_dev_ack,
           host_rdata, rx_empty, rx_count
  );
endinterface

// File: rtl/io_dev_port.sv
// Peripheral endpoint for the accumulator processor's two I/O channels.
// TX: host bytes are queued and offered on input_bus with a 4-phase
// in_dev_hs/in_dev_ack handshake. RX: processor writes are queued for the
// host and acknowledged with a one-cycle out_dev_ack pulse.
//
// TX FSM states:
//   state     | meaning
//   T_IDLE    | nothing offered; waiting for data and ack low
//   T_PRESENT | in_dev_hs high, input_bus stable, waiting for ack
//   T_RELEASE | byte taken, hs low, waiting for ack to return low
module io_dev_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          g_clk,
  input logic          g_clr,
  io_dev_port_if.slave io
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_PRESENT = 2'd1,
    T_RELEASE = 2'd2
  } tx_state_t;

  // TX channel state
  logic [WIDTH-1:0] tx_mem_q [DEPTH];
  logic [WIDTH-1:0] tx_mem_d [DEPTH];
  logic [AW-1:0]    tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0]    tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW:0]      tx_count_q, tx_count_d;
  logic             tx_full_q, tx_full_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic [WIDTH-1:0] input_bus_q, input_bus_d;
  logic             in_dev_hs_q, in_dev_hs_d;
  logic             tx_push, tx_pop;

  // RX channel state
  logic [WIDTH-1:0] rx_mem_q [DEPTH];
  logic [WIDTH-1:0] rx_mem_d [DEPTH];
  logic [AW-1:0]    rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0]    rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW:0]      rx_count_q, rx_count_d;
  logic             rx_empty_q, rx_empty_d;
  logic             out_dev_hs_q, out_dev_hs_d;
  logic             out_dev_ack_q, out_dev_ack_d;
  logic             rx_push, rx_pop;

  // TX handshake sequencing; the pop happens on the ack, not on release
  always_comb begin
    tx_state_d  = tx_state_q;
    input_bus_d = input_bus_q;
    in_dev_hs_d = in_dev_hs_q;
    tx_pop      = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        in_dev_hs_d = 1'b0;
        // a stuck-high ack holds off the next offer until it drops
        if ((tx_count_q != '0) && !io.in_dev_ack) begin
          input_bus_d = tx_mem_q[tx_rd_ptr_q];
          in_dev_hs_d = 1'b1;
          tx_state_d  = T_PRESENT;
        end
      end
      T_PRESENT: begin
        in_dev_hs_d = 1'b1;
        if (io.in_dev_ack) begin
          tx_pop      = 1'b1;
          in_dev_hs_d = 1'b0;
          tx_state_d  = T_RELEASE;
        end
      end
      T_RELEASE: begin
        in_dev_hs_d = 1'b0;
        if (!io.in_dev_ack) begin
          tx_state_d = T_IDLE;
        end
      end
      default: begin
        in_dev_hs_d = 1'b0;
        tx_state_d  = T_IDLE;
      end
    endcase
  end

  // TX FIFO bookkeeping; writes while full are discarded
  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    tx_push     = io.host_wr && !tx_full_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = io.host_wdata;
      tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase
    tx_full_d = (tx_count_d == CNT_FULL);
  end

  // RX FIFO bookkeeping; acceptance uses the registered out_dev_hs so a
  // write arriving while full is dropped even if the host reads that cycle
  always_comb begin
    rx_mem_d      = rx_mem_q;
    rx_wr_ptr_d   = rx_wr_ptr_q;
    rx_rd_ptr_d   = rx_rd_ptr_q;
    rx_count_d    = rx_count_q;
    rx_push       = io.out_wr && out_dev_hs_q;
    rx_pop        = io.host_rd && !rx_empty_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = io.output_bus;
      rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase
    rx_empty_d    = (rx_count_d == '0);
    out_dev_hs_d  = (rx_count_d < CNT_FULL);
    out_dev_ack_d = rx_push;
  end

  // state registers; reset discards all buffered bytes and any handshake
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      tx_mem_q      <= '{default: '0};
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      tx_full_q     <= 1'b0;
      tx_state_q    <= T_IDLE;
      input_bus_q   <= '0;
      in_dev_hs_q   <= 1'b0;
      rx_mem_q      <= '{default: '0};
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
      rx_empty_q    <= 1'b1;
      out_dev_hs_q  <= 1'b0;
      out_dev_ack_q <= 1'b0;
    end else begin
      tx_mem_q      <= tx_mem_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      tx_full_q     <= tx_full_d;
      tx_state_q    <= tx_state_d;
      input_bus_q   <= input_bus_d;
      in_dev_hs_q   <= in_dev_hs_d;
      rx_mem_q      <= rx_mem_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_count_q    <= rx_count_d;
      rx_empty_q    <= rx_empty_d;
      out_dev_hs_q  <= out_dev_hs_d;
      out_dev_ack_q <= out_dev_ack_d;
    end
  end

  assign io.tx_full     = tx_full_q;
  assign io.tx_count    = tx_count_q;
  assign io.input_bus   = input_bus_q;
  assign io.in_dev_hs   = in_dev_hs_q;
  assign io.out_dev_hs  = out_dev_hs_q;
  assign io.out_dev_ack = out_dev_ack_q;
  assign io.rx_empty    = rx_empty_q;
  assign io.rx_count    = rx_count_q;
  // head of the RX FIFO, read straight out of the storage registers
  assign io.host_rdata  = rx_mem_q[rx_rd_ptr_q];

endmodule

// File: tb/tb_io_dev_port.sv
// Self-checking bench for io_dev_port. Inputs change and outputs are sampled
// on the falling edge of g_clk.
module tb_io_dev_port;
  logic g_clk;
  logic g_clr;
  int   errors;
  int   checks;
  int   cyc;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  io_dev_port_if #(.WIDTH(8), .AW(2)) io ();

  io_dev_port #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .io    (io.slave)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  always @(posedge g_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    g_clr = 1'b0;
    io.host_wr = 0; io.host_wdata = 0; io.in_dev_ack = 0;
    io.output_bus = 0; io.out_wr = 0; io.host_rd = 0;
    repeat (3) @(negedge g_clk);
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL rst_in_dev_hs: got %b want 0", io.in_dev_hs); end
    checks++; if (io.out_dev_hs !== 1'b0) begin errors++; $display("FAIL rst_out_dev_hs: got %b want 0", io.out_dev_hs); end
    checks++; if (io.rx_empty !== 1'b1) begin errors++; $display("FAIL rst_rx_empty: got %b want 1", io.rx_empty); end
    checks++; if (io.tx_count !== 3'd0) begin errors++; $display("FAIL rst_tx_count: got %0d want 0", io.tx_count); end
    checks++; if (io.tx_full !== 1'b0) begin errors++; $display("FAIL rst_tx_full: got %b want 0", io.tx_full); end
    checks++; if (io.host_rdata !== 8'h00) begin errors++; $display("FAIL rst_host_rdata: got %0h want 0", io.host_rdata); end
    checks++; if (io.input_bus !== 8'h00) begin errors++; $display("FAIL rst_input_bus: got %0h want 0", io.input_bus); end
    checks++; if (io.out_dev_ack !== 1'b0) begin errors++; $display("FAIL rst_out_dev_ack: got %b want 0", io.out_dev_ack); end
    g_clr = 1'b1;
    @(negedge g_clk);
    checks++; if (io.out_dev_hs !== 1'b1) begin errors++; $display("FAIL rel_out_dev_hs: got %b want 1", io.out_dev_hs); end
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL rel_in_dev_hs: got %b want 0", io.in_dev_hs); end
    checks++; if (io.rx_empty !== 1'b1) begin errors++; $display("FAIL rel_rx_empty: got %b want 1", io.rx_empty); end
    checks++; if (io.tx_count !== 3'd0) begin errors++; $display("FAIL rel_tx_count: got %0d want 0", io.tx_count); end
  endtask

  task automatic test_tx_single();
    logic [7:0] exp;
    io.host_wr = 1; io.host_wdata = 8'hA5; tx_q.push_back(8'hA5);
    @(negedge g_clk);
    io.host_wr = 0;
    checks++; if (io.tx_count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", io.tx_count); end
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL single_hs_early: got %b want 0", io.in_dev_hs); end
    @(negedge g_clk);
    exp = tx_q.pop_front();
    checks++; if (io.in_dev_hs !== 1'b1) begin errors++; $display("FAIL single_hs_rise: got %b want 1", io.in_dev_hs); end
    checks++; if (io.input_bus !== exp) begin errors++; $display("FAIL single_bus: got %0h want %0h", io.input_bus, exp); end
    @(negedge g_clk);
    checks++; if (io.in_dev_hs !== 1'b1 || io.input_bus !== exp) begin errors++; $display("FAIL single_hold: got hs=%b bus=%0h want hs=1 bus=%0h", io.in_dev_hs, io.input_bus, exp); end
    io.in_dev_ack = 1;
    @(negedge g_clk);
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL single_hs_drop: got %b want 0", io.in_dev_hs); end
    checks++; if (io.tx_count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", io.tx_count); end
    checks++; if (io.input_bus !== exp) begin errors++; $display("FAIL single_bus_release: got %0h want %0h", io.input_bus, exp); end
    @(negedge g_clk);
    io.in_dev_ack = 0;
    repeat (2) @(negedge g_clk);
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL single_hs_idle: got %b want 0", io.in_dev_hs); end
  endtask

  task automatic test_tx_burst();
    int mcnt;
    int last_rise;
    logic got;
    logic [7:0] exp;
    mcnt = 0;
    last_rise = 0;
    for (int i = 1; i <= 5; i++) begin
      io.host_wr = 1; io.host_wdata = 8'(i);
      if (mcnt < 4) begin tx_q.push_back(8'(i)); mcnt++; end
      @(negedge g_clk);
      if (i == 4) begin
        checks++; if (io.tx_full !== 1'b1) begin errors++; $display("FAIL burst_full: got %b want 1", io.tx_full); end
      end
    end
    io.host_wr = 0;
    checks++; if (io.tx_count !== 3'd4) begin errors++; $display("FAIL burst_count: got %0d want 4", io.tx_count); end
    for (int i = 0; i < 4; i++) begin
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        if (io.in_dev_hs === 1'b1) got = 1;
        else @(negedge g_clk);
      end
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hXX;
      checks++; if (!got) begin errors++; $display("FAIL burst_hs_timeout: got none want rise %0d", i); end
      else if (io.input_bus !== exp) begin errors++; $display("FAIL burst_bus: got %0h want %0h", io.input_bus, exp); end
      if (i > 0) begin
        checks++; if (cyc - last_rise != 3) begin errors++; $display("FAIL burst_spacing: got %0d want 3", cyc - last_rise); end
      end
      last_rise = cyc;
      io.in_dev_ack = 1;
      @(negedge g_clk);
      io.in_dev_ack = 0;
      @(negedge g_clk);
    end
    checks++; if (io.tx_count !== 3'd0 || io.tx_full !== 1'b0) begin errors++; $display("FAIL burst_drain: got cnt=%0d full=%b want 0 0", io.tx_count, io.tx_full); end
    repeat (3) @(negedge g_clk);
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL burst_extra_hs: got %b want 0", io.in_dev_hs); end
  endtask

  task automatic test_tx_stuck_ack();
    logic seen;
    logic [7:0] exp;
    io.in_dev_ack = 1;
    @(negedge g_clk);
    io.host_wr = 1; io.host_wdata = 8'h3C; tx_q.push_back(8'h3C);
    @(negedge g_clk);
    io.host_wr = 0;
    seen = 0;
    repeat (4) begin
      @(negedge g_clk);
      if (io.in_dev_hs !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL stuck_hs_blocked: got 1 want 0"); end
    io.in_dev_ack = 0;
    @(negedge g_clk);
    exp = tx_q.pop_front();
    checks++; if (io.in_dev_hs !== 1'b1) begin errors++; $display("FAIL stuck_hs_rise: got %b want 1", io.in_dev_hs); end
    checks++; if (io.input_bus !== exp) begin errors++; $display("FAIL stuck_bus: got %0h want %0h", io.input_bus, exp); end
    io.in_dev_ack = 1;
    @(negedge g_clk);
    io.in_dev_ack = 0;
    repeat (2) @(negedge g_clk);
    checks++; if (io.tx_count !== 3'd0) begin errors++; $display("FAIL stuck_count: got %0d want 0", io.tx_count); end
  endtask

  task automatic test_rx_fill();
    int mcnt;
    int acks;
    logic exp_ack;
    logic [7:0] exp;
    mcnt = 0; acks = 0; exp_ack = 0;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (io.out_dev_ack !== exp_ack) begin errors++; $display("FAIL fill_ack_%0d: got %b want %b", i, io.out_dev_ack, exp_ack); end
      checks++; if (io.out_dev_hs !== (mcnt < 4)) begin errors++; $display("FAIL fill_hs_%0d: got %b want %b", i, io.out_dev_hs, (mcnt < 4)); end
      if (io.out_dev_ack === 1'b1) acks++;
      io.out_wr = 1; io.output_bus = 8'(i * 16);
      exp_ack = (mcnt < 4);
      if (exp_ack) begin rx_q.push_back(8'(i * 16)); mcnt++; end
      @(negedge g_clk);
    end
    io.out_wr = 0;
    checks++; if (io.out_dev_ack !== exp_ack) begin errors++; $display("FAIL fill_ack_drop: got %b want %b", io.out_dev_ack, exp_ack); end
    if (io.out_dev_ack === 1'b1) acks++;
    checks++; if (acks != 4) begin errors++; $display("FAIL fill_ack_count: got %0d want 4", acks); end
    checks++; if (io.out_dev_hs !== 1'b0 || io.rx_count !== 3'd4) begin errors++; $display("FAIL fill_full: got hs=%b cnt=%0d want 0 4", io.out_dev_hs, io.rx_count); end
    // full: read and write together, the write must be dropped
    exp = rx_q.pop_front();
    checks++; if (io.host_rdata !== exp) begin errors++; $display("FAIL fill_head: got %0h want %0h", io.host_rdata, exp); end
    io.host_rd = 1; io.out_wr = 1; io.output_bus = 8'h60;
    @(negedge g_clk);
    io.host_rd = 0; io.out_wr = 0;
    checks++; if (io.out_dev_ack !== 1'b0) begin errors++; $display("FAIL full_rw_ack: got %b want 0", io.out_dev_ack); end
    checks++; if (io.rx_count !== 3'd3 || io.out_dev_hs !== 1'b1) begin errors++; $display("FAIL full_rw_count: got cnt=%0d hs=%b want 3 1", io.rx_count, io.out_dev_hs); end
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      checks++; if (io.rx_empty !== 1'b0 || io.host_rdata !== exp) begin errors++; $display("FAIL drain_data: got %0h empty=%b want %0h", io.host_rdata, io.rx_empty, exp); end
      io.host_rd = 1;
      @(negedge g_clk);
    end
    io.host_rd = 0;
    checks++; if (io.rx_empty !== 1'b1 || io.rx_count !== 3'd0) begin errors++; $display("FAIL drain_empty: got empty=%b cnt=%0d want 1 0", io.rx_empty, io.rx_count); end
    io.host_rd = 1;
    @(negedge g_clk);
    io.host_rd = 0;
    checks++; if (io.rx_empty !== 1'b1 || io.rx_count !== 3'd0) begin errors++; $display("FAIL empty_read: got empty=%b cnt=%0d want 1 0", io.rx_empty, io.rx_count); end
  endtask

  task automatic test_rx_simul();
    logic [7:0] exp;
    io.out_wr = 1; io.output_bus = 8'h11; rx_q.push_back(8'h11);
    @(negedge g_clk);
    io.output_bus = 8'h22; rx_q.push_back(8'h22);
    @(negedge g_clk);
    io.out_wr = 0;
    checks++; if (io.rx_count !== 3'd2) begin errors++; $display("FAIL simul_pre_count: got %0d want 2", io.rx_count); end
    @(negedge g_clk);
    checks++; if (io.out_dev_ack !== 1'b0) begin errors++; $display("FAIL simul_pre_ack: got %b want 0", io.out_dev_ack); end
    exp = rx_q.pop_front();
    checks++; if (io.host_rdata !== exp) begin errors++; $display("FAIL simul_head0: got %0h want %0h", io.host_rdata, exp); end
    io.out_wr = 1; io.output_bus = 8'h33; io.host_rd = 1; rx_q.push_back(8'h33);
    @(negedge g_clk);
    io.out_wr = 0; io.host_rd = 0;
    checks++; if (io.rx_count !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", io.rx_count); end
    checks++; if (io.out_dev_ack !== 1'b1) begin errors++; $display("FAIL simul_ack: got %b want 1", io.out_dev_ack); end
    @(negedge g_clk);
    checks++; if (io.out_dev_ack !== 1'b0) begin errors++; $display("FAIL simul_ack_once: got %b want 0", io.out_dev_ack); end
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      checks++; if (io.host_rdata !== exp) begin errors++; $display("FAIL simul_drain: got %0h want %0h", io.host_rdata, exp); end
      io.host_rd = 1;
      @(negedge g_clk);
    end
    io.host_rd = 0;
    checks++; if (io.rx_empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b want 1", io.rx_empty); end
  endtask

  task automatic test_reset_mid();
    logic got;
    io.host_wr = 1; io.host_wdata = 8'h77;
    io.out_wr = 1; io.output_bus = 8'h99;
    @(negedge g_clk);
    io.host_wr = 0; io.out_wr = 0;
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      if (io.in_dev_hs === 1'b1) got = 1;
      else @(negedge g_clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_hs_timeout: got none want hs=1"); end
    g_clr = 1'b0;
    #1;
    checks++; if (io.in_dev_hs !== 1'b0) begin errors++; $display("FAIL mid_hs_async: got %b want 0", io.in_dev_hs); end
    checks++; if (io.tx_count !== 3'd0 || io.input_bus !== 8'h00) begin errors++; $display("FAIL mid_tx_clear: got cnt=%0d bus=%0h want 0 0", io.tx_count, io.input_bus); end
    checks++; if (io.rx_empty !== 1'b1 || io.rx_count !== 3'd0 || io.host_rdata !== 8'h00) begin errors++; $display("FAIL mid_rx_clear: got empty=%b cnt=%0d rdata=%0h want 1 0 0", io.rx_empty, io.rx_count, io.host_rdata); end
    @(negedge g_clk);
    g_clr = 1'b1;
    @(negedge g_clk);
    checks++; if (io.out_dev_hs !== 1'b1) begin errors++; $display("FAIL mid_out_hs: got %b want 1", io.out_dev_hs); end
    repeat (3) @(negedge g_clk);
    checks++; if (io.in_dev_hs !== 1'b0 || io.tx_count !== 3'd0) begin errors++; $display("FAIL mid_no_replay: got hs=%b cnt=%0d want 0 0", io.in_dev_hs, io.tx_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    test_reset();
    test_tx_single();
    test_tx_burst();
    test_tx_stuck_ack();
    test_rx_fill();
    test_rx_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
